filter_ctrl: RTL and testbench

FILTER_CTRL -- requirements
Module: filter_ctrl

---
 rtl/filter_ctrl.sv | 173 +++++++++++++++++
 tb/tb_filter_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/filter_ctrl.sv
// ============================================================================
//  Module   : filter_ctrl
//  Purpose  : Sequencer for a single-MAC FIR filter. Accepts one sample per
//             handshake, writes it into a circular sample memory, then walks
//             Order+1 taps (sample/coefficient read addresses plus MAC
//             enables) and presents the finished accumulator to a consumer.
//  Options  : FILTER_CTRL_CNT_EN - when defined, smp_cnt_o counts completed
//             outputs; otherwise smp_cnt_o is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_ctrl #(
    parameter int Order     = 127,
    parameter int AddrWidth = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_req_i,
    output logic                 in_ack_o,
    output logic                 wr_en_o,
    output logic [AddrWidth-1:0] wr_addr_o,
    output logic                 rd_en_o,
    output logic [AddrWidth-1:0] smp_addr_o,
    output logic [AddrWidth-1:0] coef_addr_o,
    output logic                 mac_en_o,
    output logic                 mac_clr_o,
    output logic                 out_req_o,
    input  logic                 out_ack_i,
    output logic                 busy_o,
    output logic [31:0]          smp_cnt_o
);

    // Reject orders that cannot be addressed by the tap index.
    if ((Order < 1) || (Order > (2**AddrWidth) - 1)) begin : g_bad_param
        $error("filter_ctrl: Order must satisfy 1 <= Order <= 2^AddrWidth-1");
    end

    localparam logic [AddrWidth-1:0] C_K_LAST = AddrWidth'(Order);
    localparam logic [AddrWidth-1:0] C_ONE    = AddrWidth'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [AddrWidth-1:0]   r_head;
    logic [AddrWidth-1:0]   r_k;
    logic                   r_mac_en;
    logic                   r_mac_clr;
    logic                   w_xfer;
    logic                   w_out_done;
    logic [AddrWidth-1:0]   w_smp_addr;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake/strobe outputs.
    always_comb begin
        w_state_next = r_state;
        in_ack_o     = 1'b0;
        wr_en_o      = 1'b0;
        rd_en_o      = 1'b0;
        out_req_o    = 1'b0;
        busy_o       = 1'b1;
        w_xfer       = 1'b0;
        w_out_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o   = 1'b0;
                in_ack_o = 1'b1;
                if (in_req_i) begin
                    wr_en_o      = 1'b1;
                    w_xfer       = 1'b1;
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                rd_en_o = 1'b1;
                if (r_k == C_K_LAST) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                out_req_o = 1'b1;
                if (out_ack_i) begin
                    w_out_done   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Head pointer: the newest sample lives at head-1 once it has advanced.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head <= '0;
        end else if (w_xfer) begin
            r_head <= r_head + C_ONE;
        end
    end

    // Tap index walks 0..Order during READ and parks at 0 otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_k <= '0;
        end else if (rd_en_o) begin
            if (r_k == C_K_LAST) begin
                r_k <= '0;
            end else begin
                r_k <= r_k + C_ONE;
            end
        end
    end

    // MAC strobes trail the read strobe by the one-cycle memory latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mac_en  <= 1'b0;
            r_mac_clr <= 1'b0;
        end else begin
            r_mac_en  <= rd_en_o;
            r_mac_clr <= rd_en_o && (r_k == '0);
        end
    end

    // Oldest-going sample address: newest (head-1) minus the tap index.
    always_comb begin
        w_smp_addr = r_head - C_ONE - r_k;
    end

    assign wr_addr_o   = wr_en_o ? r_head : '0;
    assign smp_addr_o  = rd_en_o ? w_smp_addr : '0;
    assign coef_addr_o = r_k;
    assign mac_en_o    = r_mac_en;
    assign mac_clr_o   = r_mac_clr;

`ifdef FILTER_CTRL_CNT_EN
    logic [31:0] r_cnt;

    // Completed-output counter, wraps naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_out_done) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign smp_cnt_o = r_cnt;
`else
    assign smp_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_filter_ctrl.sv
// ============================================================================
//  Module   : tb_filter_ctrl
//  Purpose  : Directed self-checking bench for filter_ctrl (Order=3,
//             AddrWidth=2) with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_ctrl;

    localparam int C_ORDER = 3;
    localparam int C_AW    = 2;
`ifdef FILTER_CTRL_CNT_EN
    localparam logic [31:0] C_CNT_EXP = 32'd3;
`else
    localparam logic [31:0] C_CNT_EXP = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_req;
    logic              out_ack;
    logic              in_ack;
    logic              wr_en;
    logic [C_AW-1:0]   wr_addr;
    logic              rd_en;
    logic [C_AW-1:0]   smp_addr;
    logic [C_AW-1:0]   coef_addr;
    logic              mac_en;
    logic              mac_clr;
    logic              out_req;
    logic              busy;
    logic [31:0]       smp_cnt;

    int n_vec = 0;
    int n_err = 0;

    filter_ctrl #(
        .Order     (C_ORDER),
        .AddrWidth (C_AW)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_req_i    (in_req),
        .in_ack_o    (in_ack),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .rd_en_o     (rd_en),
        .smp_addr_o  (smp_addr),
        .coef_addr_o (coef_addr),
        .mac_en_o    (mac_en),
        .mac_clr_o   (mac_clr),
        .out_req_o   (out_req),
        .out_ack_i   (out_ack),
        .busy_o      (busy),
        .smp_cnt_o   (smp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle; ends in the first OUTPUT cycle.
    // lst packs the four expected sample read addresses, tap 0 in the MSBs.
    task automatic run_sample(input logic [C_AW-1:0] wa, input logic [7:0] lst);
        in_req  = 1'b1;
        out_ack = 1'b0;
        #1;
        check("xfer_wr_en", wr_en, 1);
        check("xfer_wr_addr", wr_addr, wa);
        check("xfer_in_ack", in_ack, 1);
        for (int k = 0; k <= C_ORDER; k++) begin
            step;
            in_req = 1'b0;
            #1;
            check("rd_en", rd_en, 1);
            check("coef_addr", coef_addr, k);
            check("smp_addr", smp_addr, lst[(3-k)*2 +: 2]);
            check("rd_mac_en", mac_en, (k != 0));
            check("rd_mac_clr", mac_clr, (k == 1));
            check("rd_out_req", out_req, 0);
        end
        step;
        #1;
        check("drain_rd_en", rd_en, 0);
        check("drain_mac_en", mac_en, 1);
        check("drain_mac_clr", mac_clr, 0);
        check("drain_busy", busy, 1);
        check("drain_out_req", out_req, 0);
        step;
        #1;
        check("out_req", out_req, 1);
        check("out_mac_en", mac_en, 0);
        check("out_in_ack", in_ack, 0);
    endtask

    // Starts in an OUTPUT cycle; acks and ends in the following IDLE cycle.
    task automatic finish_output;
        out_ack = 1'b1;
        #1;
        check("ack_out_req", out_req, 1);
        step;
        out_ack = 1'b0;
        #1;
        check("post_ack_out_req", out_req, 0);
        check("post_ack_in_ack", in_ack, 1);
        check("post_ack_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        in_req  = 1'b0;
        out_ack = 1'b0;
        step;
        step;
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_in_ack", in_ack, 1);
        check("rst_busy", busy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_mac_clr", mac_clr, 0);
        check("rst_out_req", out_req, 0);
        check("rst_smp_addr", smp_addr, 0);
        check("rst_coef_addr", coef_addr, 0);
        check("rst_smp_cnt", smp_cnt, 0);

        // First sample: write at 0, reads 0,3,2,1
        run_sample(2'd0, {2'd0, 2'd3, 2'd2, 2'd1});

        // Consumer stalls for 10 cycles while a new sample is offered
        for (int i = 0; i < 10; i++) begin
            step;
            in_req = 1'b1;
            #1;
            check("stall_out_req", out_req, 1);
            check("stall_in_ack", in_ack, 0);
            check("stall_wr_en", wr_en, 0);
        end
        step;
        in_req = 1'b0;
        finish_output;

        // Samples 2..4 fill the ring; sample 5 wraps to address 0
        run_sample(2'd1, {2'd1, 2'd0, 2'd3, 2'd2});
        finish_output;
        run_sample(2'd2, {2'd2, 2'd1, 2'd0, 2'd3});
        finish_output;
        run_sample(2'd3, {2'd3, 2'd2, 2'd1, 2'd0});
        finish_output;
        run_sample(2'd0, {2'd0, 2'd3, 2'd2, 2'd1});
        finish_output;

        // Reset asserted at tap k=2 aborts the operation
        in_req = 1'b1;
        #1;
        check("abort_wr_en", wr_en, 1);
        check("abort_wr_addr", wr_addr, 1);
        step;
        in_req = 1'b0;
        step;
        step;
        rst = 1'b1;
        #1;
        check("abort_coef_k2", coef_addr, 2);
        step;
        rst = 1'b0;
        #1;
        check("abort_mac_en", mac_en, 0);
        check("abort_in_ack", in_ack, 1);
        check("abort_busy", busy, 0);
        check("abort_out_req", out_req, 0);
        check("abort_smp_cnt", smp_cnt, 0);
        run_sample(2'd0, {2'd0, 2'd3, 2'd2, 2'd1});
        finish_output;

        // Back-to-back: request and ack held high, one output every 7 cycles
        rst = 1'b1;
        step;
        rst     = 1'b0;
        in_req  = 1'b1;
        out_ack = 1'b1;
        #1;
        for (int i = 0; i <= 20; i++) begin
            check("b2b_wr_en", wr_en, ((i % 7) == 0) && (i <= 14));
            check("b2b_out_req", out_req, ((i % 7) == 6));
            step;
            if (i + 1 == 15) in_req = 1'b0;
            #1;
        end
        check("b2b_smp_cnt", smp_cnt, C_CNT_EXP);
        check("b2b_idle", in_ack, 1);
        out_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
